// File: rtl/pipe_reg_chain.sv
// Parametrised valid/ready pipeline register chain with per-stage back-pressure and synchronous flush.
// Optional stall counter output enabled by defining PIPE_REG_STATS_EN.
module pipe_reg_chain #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
`ifdef PIPE_REG_STATS_EN
  , parameter int unsigned    CNT_W     = 16
`endif
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_STATS_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] d [DEPTH];

  // Ready ripples from the output back toward stage 0; an empty stage is always ready.
  always_comb begin
    logic r;
    int unsigned k;
    rdy = '0;
    r   = out_ready;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      k      = DEPTH - 1 - i;
      r      = !v[k] | r;
      rdy[k] = r;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      v <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) d[k] <= RESET_VAL;
    end else if (flush) begin
      v <= '0;
    end else begin
      if (rdy[0]) begin
        v[0] <= in_valid;
        d[0] <= in_data;
      end
      for (int unsigned k = 1; k < DEPTH; k++) begin
        if (rdy[k]) begin
          v[k] <= v[k-1];
          d[k] <= d[k-1];
        end
      end
    end
  end

  assign in_ready  = rdy[0] & !flush;
  assign out_valid = v[DEPTH-1] & !flush;
  assign out_data  = d[DEPTH-1];

`ifdef PIPE_REG_STATS_EN
  // Saturating count of cycles where valid output data was refused downstream.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: two instances (DEPTH=3 and DEPTH=2) share stimulus and are
// compared every cycle against an item-list model, plus directed literal checks.
module tb_pipe_reg_chain;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        flush = 1'b0;
  logic        iv = 1'b0;
  logic        ordy = 1'b0;
  logic [31:0] id = '0;
  logic [1:0]  ir;
  logic [1:0]  ov;
  logic [31:0] od [2];
`ifdef PIPE_REG_STATS_EN
  logic [3:0]  sc0;
  logic [15:0] sc1;
  int          scnt [2] = '{0, 0};
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_reg_chain #(
    .WIDTH(32), .DEPTH(3), .RESET_VAL(32'hDEAD_BEEF)
`ifdef PIPE_REG_STATS_EN
    , .CNT_W(4)
`endif
  ) dut_a (
    .clk(clk), .clr(clr), .flush(flush),
    .in_valid(iv), .in_ready(ir[0]), .in_data(id),
    .out_valid(ov[0]), .out_ready(ordy), .out_data(od[0])
`ifdef PIPE_REG_STATS_EN
    , .stall_cnt(sc0)
`endif
  );

  pipe_reg_chain #(
    .WIDTH(32), .DEPTH(2), .RESET_VAL(32'h0)
`ifdef PIPE_REG_STATS_EN
    , .CNT_W(16)
`endif
  ) dut_b (
    .clk(clk), .clr(clr), .flush(flush),
    .in_valid(iv), .in_ready(ir[1]), .in_data(id),
    .out_valid(ov[1]), .out_ready(ordy), .out_data(od[1])
`ifdef PIPE_REG_STATS_EN
    , .stall_cnt(sc1)
`endif
  );

  // Model: per instance, an ordered list of in-flight items (oldest first) with their stage index.
  int          mn [2] = '{0, 0};
  int          mp [2][8];
  logic [31:0] md [2][8];
  logic [31:0] outb [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int dep(input int n);
    return (n == 0) ? 3 : 2;
  endfunction

  // An item advances if the next stage is empty or its occupant advances (or leaves).
  function automatic logic [7:0] moves(input int n, input logic ordy_s);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < mn[n]; i++) begin
      if (i == 0) m[i] = (mp[n][0] < dep(n) - 1) || ordy_s;
      else        m[i] = (mp[n][i-1] > mp[n][i] + 1) || m[i-1];
    end
    return m;
  endfunction

  function automatic logic exp_iready(input int n, input logic fl, input logic ordy_s);
    logic [7:0] m;
    if (fl) return 1'b0;
    if (mn[n] == 0) return 1'b1;
    m = moves(n, ordy_s);
    return (mp[n][mn[n]-1] > 0) || m[mn[n]-1];
  endfunction

  function automatic logic exp_ovalid(input int n, input logic fl);
    return !fl && (mn[n] > 0) && (mp[n][0] == dep(n) - 1);
  endfunction

  function automatic void step(input int n, input logic iv_s, input logic [31:0] id_s, input logic ordy_s);
    logic [7:0] m;
    logic acc;
    m   = moves(n, ordy_s);
    acc = iv_s && exp_iready(n, 1'b0, ordy_s);
    for (int i = 0; i < mn[n]; i++) if (m[i]) mp[n][i]++;
    if (mn[n] > 0 && mp[n][0] == dep(n)) begin
      for (int i = 1; i < mn[n]; i++) begin
        mp[n][i-1] = mp[n][i];
        md[n][i-1] = md[n][i];
      end
      mn[n]--;
    end
    if (acc) begin
      mp[n][mn[n]] = 0;
      md[n][mn[n]] = id_s;
      mn[n]++;
    end
  endfunction

  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
`ifdef PIPE_REG_STATS_EN
      if (clr) scnt[n] = 0;
      else if (exp_ovalid(n, flush) && !ordy && scnt[n] < ((n == 0) ? 15 : 65535)) scnt[n]++;
`endif
      if (clr || flush) mn[n] = 0;
      else step(n, iv, id, ordy);
    end
  end

  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("in_ready[%0d]", n), {31'b0, ir[n]}, {31'b0, exp_iready(n, flush, ordy)});
      chk($sformatf("out_valid[%0d]", n), {31'b0, ov[n]}, {31'b0, exp_ovalid(n, flush)});
      if (exp_ovalid(n, flush)) chk($sformatf("out_data[%0d]", n), od[n], md[n][0]);
    end
    if (ov[1] && ordy) outb.push_back(od[1]);
`ifdef PIPE_REG_STATS_EN
    chk("stall_cnt[0]", {28'b0, sc0}, scnt[0]);
    chk("stall_cnt[1]", {16'b0, sc1}, scnt[1]);
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    mn[0] = 0;
    mn[1] = 0;
`ifdef PIPE_REG_STATS_EN
    scnt[0] = 0;
    scnt[1] = 0;
`endif
  endtask

  task automatic do_reset();
    cyc();
    clr = 1'b1; iv = 1'b0; flush = 1'b0;
    clear_model();
    cyc();
    clr = 1'b0;
  endtask

  initial begin
    do_reset();

    // Reset mid-stream on the DEPTH=3 instance
    ordy = 1'b0; iv = 1'b1; id = 32'h11;
    cyc(); id = 32'h22;
    cyc(); id = 32'h33;
    cyc(); cyc();
    @(negedge clk);
    chk("t1_full_valid", {31'b0, ov[0]}, 32'd1);
    cyc();
    clr = 1'b1;
    clear_model();
    #1;
    chk("t1_clr_valid", {31'b0, ov[0]}, 32'd0);
    chk("t1_clr_data", od[0], 32'hDEAD_BEEF);
    chk("t1_clr_ready", {31'b0, ir[0]}, 32'd1);
    chk("t1_clr_data_b", od[1], 32'h0);
    cyc();
    clr = 1'b0; iv = 1'b0;

    // Streaming on DEPTH=3
    ordy = 1'b1; iv = 1'b1; id = 32'd1;
    @(negedge clk); chk("t2_ready", {31'b0, ir[0]}, 32'd1);
    cyc(); id = 32'd2;
    @(negedge clk); chk("t2_lat1", {31'b0, ov[0]}, 32'd0);
    cyc(); id = 32'd3;
    @(negedge clk); chk("t2_lat2", {31'b0, ov[0]}, 32'd0);
    cyc(); id = 32'd4;
    @(negedge clk); chk("t2_first_valid", {31'b0, ov[0]}, 32'd1); chk("t2_d1", od[0], 32'd1);
    cyc(); iv = 1'b0;
    @(negedge clk); chk("t2_d2", od[0], 32'd2);
    cyc();
    @(negedge clk); chk("t2_d3", od[0], 32'd3);
    cyc();
    @(negedge clk); chk("t2_d4", od[0], 32'd4);
    cyc();
    @(negedge clk); chk("t2_empty", {31'b0, ov[0]}, 32'd0);

    // Back-pressure on DEPTH=2
    do_reset();
    ordy = 1'b0; iv = 1'b1; id = 32'hA;
    cyc(); id = 32'hB;
    cyc(); id = 32'hC;
    @(negedge clk); chk("t3_ready_drop", {31'b0, ir[1]}, 32'd0); chk("t3_head", od[1], 32'hA);
    cyc();
    @(negedge clk); chk("t3_hold_ready", {31'b0, ir[1]}, 32'd0); chk("t3_hold_head", od[1], 32'hA);
    cyc(); ordy = 1'b1;
    @(negedge clk); chk("t3_ready_comb", {31'b0, ir[1]}, 32'd1); chk("t3_dA", od[1], 32'hA);
    cyc(); iv = 1'b0;
    @(negedge clk); chk("t3_dB", od[1], 32'hB);
    cyc();
    @(negedge clk); chk("t3_dC", od[1], 32'hC); chk("t3_vC", {31'b0, ov[1]}, 32'd1);
    cyc();
    @(negedge clk); chk("t3_empty", {31'b0, ov[1]}, 32'd0);

    // Flush on DEPTH=2 holding 5,6 while 7 is offered
    do_reset();
    ordy = 1'b0; iv = 1'b1; id = 32'd5;
    cyc(); id = 32'd6;
    cyc(); id = 32'd7; flush = 1'b1;
    @(negedge clk); chk("t4_flush_ready", {31'b0, ir[1]}, 32'd0); chk("t4_flush_valid", {31'b0, ov[1]}, 32'd0);
    cyc(); flush = 1'b0; iv = 1'b0; ordy = 1'b1;
    @(negedge clk); chk("t4_after_valid", {31'b0, ov[1]}, 32'd0); chk("t4_after_ready", {31'b0, ir[1]}, 32'd1);
    repeat (3) begin
      cyc();
      @(negedge clk); chk("t4_no7", {31'b0, ov[1]}, 32'd0);
    end

    // Multi-cycle flush keeps everything closed
    iv = 1'b1; id = 32'h55;
    cyc(); cyc(); flush = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flushN_ready", {30'b0, ir}, 32'd0);
      chk("flushN_valid", {30'b0, ov}, 32'd0);
      cyc();
    end
    flush = 1'b0; iv = 1'b0;

    // Full throughput on DEPTH=2
    do_reset();
    ordy = 1'b1;
    outb.delete();
    for (int i = 0; i < 10; i++) begin
      iv = 1'b1; id = 32'd100 + 32'(i);
      @(negedge clk); chk("t5_ready", {31'b0, ir[1]}, 32'd1);
      cyc();
    end
    iv = 1'b0;
    repeat (4) cyc();
    chk("t5_count", 32'(outb.size()), 32'd10);
    for (int i = 0; i < 10 && i < outb.size(); i++) chk("t5_order", outb[i], 32'd100 + 32'(i));

`ifdef PIPE_REG_STATS_EN
    // Saturating stall counter on the CNT_W=4 instance
    do_reset();
    ordy = 1'b0; iv = 1'b1; id = 32'h77;
    repeat (25) cyc();
    @(negedge clk); chk("t6_sat", {28'b0, sc0}, 32'd15);
    cyc(); flush = 1'b1;
    cyc(); flush = 1'b0; iv = 1'b0;
    @(negedge clk); chk("t6_flush_keep", {28'b0, sc0}, 32'd15);
    cyc();
    clr = 1'b1;
    clear_model();
    #1; chk("t6_clr", {28'b0, sc0}, 32'd0);
    cyc(); clr = 1'b0;
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      cyc();
      clr   = ($urandom % 64) == 0;
      if (clr) clear_model();
      flush = ($urandom % 12) == 0;
      iv    = ($urandom % 4) != 0;
      id    = $urandom;
      ordy  = ($urandom % 3) != 0;
    end
    cyc();
    clr = 1'b0; flush = 1'b0; iv = 1'b0; ordy = 1'b1;
    repeat (5) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
